// File: rtl/mlp_infer_sched.sv
// Round-robin request scheduler for the combinational printed-MLP classifier: grants one
// requester, holds its features on mlp_inp for EVAL_CYCLES cycles, then returns the class.
module mlp_infer_sched #(
  parameter int N_REQ       = 2,
  parameter int IN_W        = 32,
  parameter int OUT_W       = 2,
  parameter int N_CLASS     = 3,
  parameter int EVAL_CYCLES = 3,
  localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*IN_W-1:0]   req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [IN_W-1:0]         mlp_inp,
  input  logic [OUT_W-1:0]        mlp_out,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [OUT_W-1:0]        rsp_class,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EVAL = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam int CNT_W = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(EVAL_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_RST  = ID_W'(N_REQ - 1);
  localparam logic [OUT_W:0]   N_CLASS_V = (OUT_W + 1)'(N_CLASS);

  logic [1:0]       state_q, state_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0]  inp_q, inp_d;
  logic             rv_q, rv_d;
  logic [OUT_W-1:0] cls_q, cls_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             err_q, err_d;
  logic             busy_q;

  logic [ID_W-1:0]  cand;
  logic [ID_W-1:0]  win_idx;
  logic [IN_W-1:0]  win_data;
  logic             accept;

  // Scan from the highest offset down so the last hit is the nearest requester after last_q.
  always_comb begin
    cand    = '0;
    win_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(last_q) + k) % N_REQ);
      if (req_valid[cand]) win_idx = cand;
    end
  end

  assign win_data = req_data[int'(win_idx)*IN_W +: IN_W];

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // Requesters hold valid/data until accepted; the response stays valid until rsp_ready.
  always_comb begin
    req_ready = '0;
    if (!rst && state_q == IDLE && |req_valid) req_ready[win_idx] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    inp_d   = inp_q;
    rv_d    = rv_q;
    cls_d   = cls_q;
    id_d    = id_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          inp_d   = win_data;
          id_d    = win_idx;
          last_d  = win_idx;
          cnt_d   = CNT_LOAD;
          state_d = EVAL;
        end
      end
      EVAL: begin
        // mlp_inp is frozen here, so the classifier path is an EVAL_CYCLES multicycle path.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cls_d   = mlp_out;
          err_d   = ({1'b0, mlp_out} >= N_CLASS_V);
          rv_d    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (rv_q && rsp_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      inp_q   <= '0;
      rv_q    <= 1'b0;
      cls_q   <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      inp_q   <= inp_d;
      rv_q    <= rv_d;
      cls_q   <= cls_d;
      id_q    <= id_d;
      err_q   <= err_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign mlp_inp   = inp_q;
  assign rsp_valid = rv_q;
  assign rsp_class = cls_q;
  assign rsp_id    = id_q;
  assign rsp_err   = err_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mlp_infer_sched.sv
// Bench for mlp_infer_sched: vector table, corner-case sequences and a random run checked
// against a transaction-level model with an expected-response queue.
module tb_mlp_infer_sched;
  localparam int N_REQ = 2;
  localparam int N_CLASS = 3;
  localparam int EVAL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid, req_ready;
  logic [63:0] req_data;
  logic [31:0] mlp_inp;
  logic [1:0]  mlp_out, rsp_class, dbg_state;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [0:0]  rsp_id;
  logic        ovr_en;
  logic [1:0]  ovr_val;

  logic [1:0]  req_valid_b, req_ready_b;
  logic [63:0] req_data_b;
  logic [31:0] mlp_inp_b;
  logic [1:0]  mlp_out_b, rsp_class_b, dbg_state_b;
  logic        rsp_valid_b, rsp_ready_b, rsp_err_b, busy_b;
  logic [0:0]  rsp_id_b;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [35:0] exp_q[$];

  // Classifier stand-in: class = low two feature bits + 1, so all-zero features give class 1.
  function automatic logic [1:0] stub_cls(input logic [31:0] x);
    return x[1:0] + 2'd1;
  endfunction

  assign mlp_out   = ovr_en ? ovr_val : stub_cls(mlp_inp);
  assign mlp_out_b = stub_cls(mlp_inp_b);

  mlp_infer_sched #(.N_REQ(2), .IN_W(32), .OUT_W(2), .N_CLASS(3), .EVAL_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .mlp_inp(mlp_inp), .mlp_out(mlp_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_class(rsp_class), .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy), .dbg_state(dbg_state)
  );

  mlp_infer_sched #(.N_REQ(2), .IN_W(32), .OUT_W(2), .N_CLASS(3), .EVAL_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_data(req_data_b), .req_ready(req_ready_b),
    .mlp_inp(mlp_inp_b), .mlp_out(mlp_out_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_class(rsp_class_b), .rsp_id(rsp_id_b), .rsp_err(rsp_err_b), .busy(busy_b),
    .dbg_state(dbg_state_b)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0; req_data = '0; rsp_ready = 1'b0; ovr_en = 1'b0; ovr_val = '0;
    req_valid_b = '0; req_data_b = '0; rsp_ready_b = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    int n;
    n = 0;
    #1;
    while (!rsp_valid && n < 30) begin
      @(negedge clk); #1; n++;
    end
    chk(name, rsp_valid, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk); #1;
    while ((busy || rsp_valid) && n < 30) begin
      @(negedge clk); #1; n++;
    end
    chk(name, busy, 1'b0);
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        ovr;
    logic [1:0]  ovr_val;
    logic [0:0]  exp_id;
    logic [1:0]  exp_cls;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic run_row(input int r, input vec_t v);
    int lat;
    logic [31:0] exp_inp;
    exp_inp = v.exp_id[0] ? v.d1 : v.d0;
    @(negedge clk);
    req_valid = v.valid; req_data = {v.d1, v.d0}; rsp_ready = 1'b1;
    ovr_en = v.ovr; ovr_val = v.ovr_val;
    #1;
    chk($sformatf("row%0d_grant", r), req_ready, v.exp_id[0] ? 2'b10 : 2'b01);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    #1;
    lat = 0;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); @(negedge clk); #1; lat++;
    end
    chk($sformatf("row%0d_latency", r), lat, 3);
    chk($sformatf("row%0d_rsp", r), {rsp_id, rsp_class, rsp_err}, {v.exp_id, v.exp_cls, v.exp_err});
    chk($sformatf("row%0d_inp", r), mlp_inp, exp_inp);
    chk($sformatf("row%0d_busy", r), busy, 1'b1);
    @(posedge clk);
    @(negedge clk); #1;
    chk($sformatf("row%0d_drop", r), {rsp_valid, busy}, 2'b00);
  endtask

  task automatic random_phase(input int ncyc);
    logic [1:0]  pend;
    logic [31:0] pd[2];
    logic [1:0]  exp_rdy;
    logic [1:0]  cls;
    logic        err;
    int m_phase, m_left, m_last, w;
    pend = '0; pd[0] = '0; pd[1] = '0;
    m_phase = 0; m_left = 0; m_last = N_REQ - 1;
    exp_q.delete();
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          pd[i] = $urandom;
        end else if (pend[i] && $urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end
      end
      req_valid = pend; req_data = {pd[1], pd[0]};
      rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      w = -1;
      if (m_phase == 0) begin
        for (int k = 1; k <= N_REQ; k++) begin
          if (w < 0 && pend[(m_last + k) % N_REQ]) w = (m_last + k) % N_REQ;
        end
      end
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("rnd_ready", req_ready, exp_rdy);
      chk("rnd_rsp_valid", rsp_valid, m_phase == 2);
      chk("rnd_busy", busy, m_phase != 0);
      if (m_phase != 0) chk("rnd_inp", mlp_inp, exp_q[0][31:0]);
      if (m_phase == 2) chk("rnd_rsp", {rsp_id, rsp_class, rsp_err, mlp_inp}, exp_q[0]);
      if (w >= 0) begin
        cls = stub_cls(pd[w]);
        err = (cls >= N_CLASS);
        exp_q.push_back({w[0], cls, err, pd[w]});
        m_last = w; pend[w] = 1'b0; m_phase = 1; m_left = EVAL;
      end else if (m_phase == 1) begin
        m_left--;
        if (m_left == 0) m_phase = 2;
      end else if (m_phase == 2 && rsp_ready) begin
        void'(exp_q.pop_front());
        m_phase = 0;
      end
      @(posedge clk);
    end
  endtask

  initial begin
    int na, nr;
    int acc_id[4], acc_cyc[4], rid[4];
    logic [31:0] d_b;

    vecs[0] = '{2'b11, 32'h0000_0000, 32'h0000_0004, 1'b0, 2'b00, 1'b0, 2'd1, 1'b0};
    vecs[1] = '{2'b11, 32'h1111_2222, 32'hA5A5_0005, 1'b0, 2'b00, 1'b1, 2'd2, 1'b0};
    vecs[2] = '{2'b11, 32'h0000_0002, 32'h0000_0008, 1'b0, 2'b00, 1'b0, 2'd3, 1'b1};
    vecs[3] = '{2'b11, 32'h0000_0010, 32'h0000_00F0, 1'b1, 2'b11, 1'b1, 2'd3, 1'b1};
    vecs[4] = '{2'b01, 32'h0000_0003, 32'h0000_0000, 1'b1, 2'b10, 1'b0, 2'd2, 1'b0};
    vecs[5] = '{2'b10, 32'h0000_0000, 32'hDEAD_BEE3, 1'b0, 2'b00, 1'b1, 2'd0, 1'b0};

    // Reset values, with a request already pending during reset
    rst = 1'b1;
    req_valid = 2'b01; req_data = 64'h0000_0001_0000_0001; rsp_ready = 1'b1;
    ovr_en = 1'b0; ovr_val = '0;
    req_valid_b = '0; req_data_b = '0; rsp_ready_b = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_outs", {rsp_valid, busy, rsp_class, rsp_id, rsp_err}, '0);
    chk("rst_inp", mlp_inp, 32'h0);
    @(negedge clk);
    rst = 1'b0; req_valid = '0;

    for (int r = 0; r < 6; r++) run_row(r, vecs[r]);
    ovr_en = 1'b0;

    // Both requesters continuously valid: grants alternate, accepts 5 cycles apart
    @(negedge clk);
    req_valid = 2'b11; req_data = {32'hB0B0_0001, 32'hA0A0_0000}; rsp_ready = 1'b1;
    na = 0; nr = 0;
    for (int c = 0; c < 60 && nr < 4; c++) begin
      if (na >= 4) req_valid = '0;
      #1;
      if (rsp_valid && nr < 4) begin rid[nr] = int'(rsp_id); nr++; end
      if (|(req_valid & req_ready) && na < 4) begin
        acc_id[na] = int'(req_ready[1]); acc_cyc[na] = cyc; na++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    chk("rr_count", {na[7:0], nr[7:0]}, {8'd4, 8'd4});
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_grant%0d", i), acc_id[i], i % 2);
      chk($sformatf("rr_rsp_id%0d", i), rid[i], i % 2);
    end
    for (int i = 1; i < 4; i++) chk($sformatf("rr_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], 5);
    wait_idle("rr_idle");

    // Response back-pressure: everything frozen in HOLD, no grant until after the handshake
    @(negedge clk);
    req_valid = 2'b01; req_data = {32'h0000_0777, 32'h0000_0C01}; rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b10;
    wait_rsp("hold_rsp_seen");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      chk($sformatf("hold_stable%0d", c), {rsp_valid, rsp_id, rsp_class, rsp_err, req_ready, mlp_inp},
          {1'b1, 1'b0, 2'd2, 1'b0, 2'b00, 32'h0000_0C01});
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("hold_no_early_grant", req_ready, 2'b00);
    @(posedge clk);
    @(negedge clk); #1;
    chk("hold_grant_after", {rsp_valid, req_ready}, {1'b0, 2'b10});
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    wait_idle("hold_idle");

    // Asynchronous reset in the middle of EVAL
    @(negedge clk);
    req_valid = 2'b10; req_data = {32'h5555_AAA9, 32'h0000_0000}; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("arst_in_eval", busy, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_outs", {rsp_valid, busy, rsp_class, rsp_id, rsp_err, req_ready}, '0);
    chk("arst_inp", mlp_inp, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("arst_no_rsp", {rsp_valid, req_ready}, '0);
    rst = 1'b0;
    #1;
    chk("arst_regrant", req_ready, 2'b10);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    wait_rsp("arst_rsp_seen");
    chk("arst_rsp", {rsp_id, rsp_class, rsp_err, mlp_inp}, {1'b1, 2'd2, 1'b0, 32'h5555_AAA9});
    wait_idle("arst_idle");

    // Single-cycle settle window on the second instance
    d_b = 32'h1234_5671;
    @(negedge clk);
    req_valid_b = 2'b01; req_data_b = {32'h0, d_b}; rsp_ready_b = 1'b0;
    #1;
    chk("e1_grant", req_ready_b, 2'b01);
    @(posedge clk);
    @(negedge clk);
    req_valid_b = '0;
    #1;
    chk("e1_eval", {rsp_valid_b, busy_b, mlp_inp_b}, {1'b0, 1'b1, d_b});
    @(negedge clk); #1;
    chk("e1_capture", {rsp_valid_b, rsp_id_b, rsp_class_b, rsp_err_b, mlp_inp_b},
        {1'b1, 1'b0, 2'd2, 1'b0, d_b});
    @(negedge clk); #1;
    chk("e1_hold", {rsp_valid_b, mlp_inp_b, req_ready_b}, {1'b1, d_b, 2'b00});
    rsp_ready_b = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    chk("e1_done", {rsp_valid_b, busy_b, mlp_inp_b}, {1'b0, 1'b0, d_b});

    random_phase(2500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
